// File: rtl/fpu_sequencer.sv
// Issue/sequencing controller in front of the fpu datapath: one request at a time,
// rounding-mode resolution, per-op latency wait, tagged response. Optional flush: FPU_SEQ_FLUSH_EN.
module fpu_sequencer #(
  parameter int unsigned FLEN     = 32,
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 16,
  parameter int unsigned LAT_SQRT = 16,
  parameter int unsigned LAT_CVT  = 1
) (
  input  logic            clk,
  input  logic            resetn,
`ifdef FPU_SEQ_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [5:0]      req_op,
  input  logic [FLEN-1:0] req_rs1,
  input  logic [FLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic [2:0]      req_rm,
  input  logic [31:0]     fcsr,
  output logic [5:0]      fpu_operation,
  output logic [FLEN-1:0] fpu_rs1,
  output logic [FLEN-1:0] fpu_rs2,
  output logic [31:0]     fpu_fcsr,
  input  logic [FLEN-1:0] fpu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [FLEN-1:0] rsp_result,
  output logic [4:0]      rsp_rd,
  output logic            rsp_illegal,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] CNT_ADD  = 5'(LAT_ADD - 1);
  localparam logic [4:0] CNT_MUL  = 5'(LAT_MUL - 1);
  localparam logic [4:0] CNT_DIV  = 5'(LAT_DIV - 1);
  localparam logic [4:0] CNT_SQRT = 5'(LAT_SQRT - 1);
  localparam logic [4:0] CNT_CVT  = 5'(LAT_CVT - 1);

  state_t     state, state_nxt;
  logic [4:0] cnt;
  logic [4:0] cnt_init;
  logic [2:0] rm_q;
  logic [2:0] rm_res;
  logic       illegal;
  logic       accept;
  logic       kill;

`ifdef FPU_SEQ_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign req_ready = (state == IDLE) && !kill;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign accept    = req_valid && req_ready;
  // Only the rm field is frozen per operation; the remaining fcsr bits pass through live.
  assign fpu_fcsr  = {fcsr[31:8], rm_q, fcsr[4:0]};

  always_comb begin
    rm_res  = (req_rm == 3'd7) ? fcsr[7:5] : req_rm;
    illegal = (req_op > 6'd5) || (rm_res >= 3'd5);
    case (req_op)
      6'd0:    cnt_init = CNT_ADD;
      6'd1:    cnt_init = CNT_MUL;
      6'd2:    cnt_init = CNT_DIV;
      6'd3:    cnt_init = CNT_SQRT;
      default: cnt_init = CNT_CVT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = illegal ? DONE : EXEC;
      EXEC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      rm_q          <= '0;
      fpu_operation <= '0;
      fpu_rs1       <= '0;
      fpu_rs2       <= '0;
      rsp_result    <= '0;
      rsp_rd        <= '0;
      rsp_illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_rd <= req_rd;
            if (illegal) begin
              rsp_result  <= '0;
              rsp_illegal <= 1'b1;
            end else begin
              fpu_operation <= req_op;
              fpu_rs1       <= req_rs1;
              fpu_rs2       <= req_rs2;
              rm_q          <= rm_res;
              cnt           <= cnt_init;
            end
          end
        end
        EXEC: begin
          if (!kill) begin
            if (cnt != '0) begin
              cnt <= cnt - 5'd1;
            end else begin
              rsp_result  <= fpu_result;
              rsp_illegal <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fpu_sequencer.md
# fpu_sequencer

Issue/sequencing controller in front of the `fpu` datapath. It accepts one floating-point request at a time from the core over a valid/ready handshake and resolves the rounding mode (static, or dynamic from `fcsr.frm`). It drives the FPU operand, operation and `fcsr` inputs, waits the per-operation latency, and captures the result. The result is returned on a valid/ready response channel tagged with the destination register. Illegal operations and illegal rounding modes are rejected without using the FPU.

## Interface
Parameters:
- `FLEN`, 32: operand/result width.
- `LAT_ADD`, 3: cycles for op 0 (fpadd); must be ≥1.
- `LAT_MUL`, 3: cycles for op 1 (fmul); must be ≥1.
- `LAT_DIV`, 16: cycles for op 2 (fdiv); must be ≥1.
- `LAT_SQRT`, 16: cycles for op 3 (fsqrt); must be ≥1.
- `LAT_CVT`, 1: cycles for ops 4/5 (fcvt_s_w / fcvt_s_wu); must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 6: operation code (0–5 legal).
- `req_rs1` in FLEN: operand 1.
- `req_rs2` in FLEN: operand 2.
- `req_rd` in 5: destination tag.
- `req_rm` in 3: rounding mode; 7 = dynamic.
- `fcsr` in 32: architectural fcsr; `frm` = [7:5].
- `fpu_operation` out 6: to FPU `operation`.
- `fpu_rs1` out FLEN: to FPU `rs1`.
- `fpu_rs2` out FLEN: to FPU `rs2`.
- `fpu_fcsr` out 32: to FPU `fcsr`, carrying the resolved rounding mode.
- `fpu_result` in FLEN: from FPU `result`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_result` out FLEN: registered result.
- `rsp_rd` out 5: destination tag of the response.
- `rsp_illegal` out 1: request was rejected.
- `busy` out 1: state ≠ IDLE.
- `flush` in 1: kill the in-flight operation (present only with `FPU_SEQ_FLUSH_EN`).

## Operation
- **States:** IDLE, EXEC, DONE. The state is encoded in 2 bits.
- **IDLE**
  - `req_ready`=1 (gated by `flush` when configured).
  - Accept occurs on `req_valid && req_ready`. It captures op, rs1, rs2 and rd.
  - It also captures the resolved rm: `req_rm`, or `fcsr[7:5]` sampled on the accept edge when `req_rm`==7.
- **Illegal check at accept:** `req_op`>5, or resolved rm ∈ {5,6,7}.
  - Transition straight to DONE with `rsp_result`=0 and `rsp_illegal`=1.
  - The FPU outputs are not updated.
- **Legal accept:** transition to EXEC and load `cnt` = LAT(op)−1.
  - The counter is 5 bits wide; latency parameters above 32 are unsupported.
- **EXEC**
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`==0, register `fpu_result` into `rsp_result`, set `rsp_illegal`=0, and go to DONE.
- **DONE**
  - `rsp_valid`=1, `req_ready`=0.
  - On `rsp_ready` return to IDLE.
  - `rsp_result`, `rsp_rd` and `rsp_illegal` stay stable while `rsp_valid && !rsp_ready`.
- **FPU drive**
  - `fpu_operation`, `fpu_rs1` and `fpu_rs2` are registered from the capture on a legal accept.
  - They hold their values through EXEC, DONE and the following IDLE until the next legal accept.
- **`fpu_fcsr`** = {`fcsr[31:8]`, resolved_rm, `fcsr[4:0]`}.
  - Bits [31:8] and [4:0] follow `fcsr` live.
  - The rm field is the registered resolved value.
- **`fcsr` changes:** a change to `fcsr` after accept does not alter the rounding mode of the in-flight operation.
- **Reset (`resetn`=0):** state=IDLE, `cnt`=0, and every registered output = 0.
  - As a result, `req_ready`=1, `rsp_valid`=0 and `busy`=0 during reset.
- **Reset asserted mid-EXEC or mid-DONE:** the operation is dropped and no response is produced.

## Timing
- **Legal op:** accept at edge E. `fpu_*` outputs are valid from E.
  - The result is sampled at edge E+LAT(op).
  - `rsp_valid` is high from E+LAT(op) onward.
- **Illegal op:** `rsp_valid` is high from edge E+1.
- **Throughput:** one outstanding request. With `rsp_ready` held at 1, the next accept is possible at edge E+LAT+2.
- **Response backpressure:** `rsp_valid` stays high indefinitely while `rsp_ready`=0. No new request is accepted during that time.
- **Combinational paths:** `req_ready` and `busy` are decoded from the state register. There is no combinational path from `req_valid` to `req_ready`.

## Configuration
- **`FPU_SEQ_FLUSH_EN` defined:** the `flush` port exists.
  - `flush`=1 in EXEC or DONE forces IDLE at the next edge, deasserts `rsp_valid`, and produces no response.
  - In IDLE, `flush`=1 forces `req_ready`=0, so no accept occurs.
  - `flush` takes priority over `rsp_ready` and over counter expiry.
- **`FPU_SEQ_FLUSH_EN` undefined:** there is no `flush` port, and every accepted request produces exactly one response.

## Test plan
- **Reset:** assert `resetn`=0 mid-EXEC of an fdiv → `rsp_valid`=0, `busy`=0, `req_ready`=1. After release, no stale response appears.
- **fadd, static rm:** op=0, rs1=0x3F800000, rs2=0x40000000, rm=0, rd=5, FPU model returns 0x40400000 → `rsp_valid` rises exactly 3 cycles after accept, with result=0x40400000, rd=5, illegal=0, and `fpu_fcsr[7:5]`=0.
- **Dynamic rm:** op=4, rm=7, `fcsr[7:5]`=3 → `fpu_fcsr[7:5]`=3. Changing `fcsr[7:5]` to 1 during EXEC leaves `fpu_fcsr[7:5]`=3; the response arrives after 1 cycle.
- **Illegal cases:**
  - op=9 → `rsp_valid` 1 cycle after accept, illegal=1, result=0, and `fpu_operation` unchanged.
  - op=0 with rm=6 → same response.
- **Backpressure:** fsqrt with `rsp_ready`=0 for 10 cycles → `rsp_valid` and all response fields held stable, and `req_ready`=0 throughout. Raising `rsp_ready` gives IDLE on the next edge.
- **Flush (`FPU_SEQ_FLUSH_EN`):** `flush` pulse 4 cycles into an fdiv → IDLE next edge and no response. A subsequent fmul completes normally in 3 cycles.
